baugh_wooley_mul16: RTL and testbench

//  - Signed two's-complement multiplier, WIDTH x WIDTH -> 2*WIDTH, Baugh-Wooley array.
//  - No sign-extension of partial products; no Booth recoding.
//  - Arithmetic datapath leaf: operands sampled on a valid strobe, registered product out.
//  - Used wherever a fixed-latency signed product is needed.

---
 rtl/bw_mul_pkg.sv | 21 ++
 rtl/baugh_wooley_mul16_csa_row.sv | 26 ++
 rtl/baugh_wooley_mul16.sv | 115 +++++++++++
 tb/tb_baugh_wooley_mul16.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/bw_mul_pkg.sv
// +----------------------------------------------------------------------+
// | bw_mul_pkg                                                           |
// | Shared width helpers and operand/product types for the BW multiplier |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package bw_mul_pkg;

   localparam int BW_DEF_WIDTH = 16;

   function automatic int bw_pwidth(input int w);
      return 2 * w;
   endfunction

   typedef logic signed [BW_DEF_WIDTH-1:0]            bw_operand_t;
   typedef logic signed [bw_pwidth(BW_DEF_WIDTH)-1:0] bw_product_t;

endpackage

`default_nettype wire

// File: rtl/baugh_wooley_mul16_csa_row.sv
// +----------------------------------------------------------------------+
// | bw_csa_row                                                           |
// | Carry-save adder row: N independent full adders, carry unshifted     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module bw_csa_row
   import bw_mul_pkg::*;
#(
   parameter int N = bw_pwidth(BW_DEF_WIDTH)
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   input  logic [N-1:0] c_i,
   output logic [N-1:0] sum_o,
   output logic [N-1:0] carry_o
);

   // carry_o[k] carries weight 2^(k+1); the caller applies the shift.
   assign sum_o   = a_i ^ b_i ^ c_i;
   assign carry_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

`default_nettype wire

// File: rtl/baugh_wooley_mul16.sv
// +----------------------------------------------------------------------+
// | baugh_wooley_mul16                                                   |
// | Signed WIDTH x WIDTH Baugh-Wooley array multiplier, registered out.  |
// | Optional macro BW_MUL_PIPE_EN adds a stage before the final adder.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module baugh_wooley_mul16
   import bw_mul_pkg::*;
#(
   parameter int WIDTH = BW_DEF_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   input  logic [WIDTH-1:0]     X,
   input  logic [WIDTH-1:0]     Y,
   output logic                 out_valid,
   output logic [2*WIDTH-1:0]   P
);

   localparam int PW = bw_pwidth(WIDTH);

   // Baugh-Wooley correction: +2^WIDTH and +2^(2*WIDTH-1).
   localparam logic [PW-1:0] C_CORR = {1'b1, {(WIDTH-2){1'b0}}, 1'b1, {WIDTH{1'b0}}};

   logic [WIDTH-1:0][WIDTH-1:0] w_pp;
   logic [WIDTH-1:0][PW-1:0]    w_row;
   logic [WIDTH-2:0][PW-1:0]    w_acc_s;
   logic [WIDTH-2:0][PW-1:0]    w_acc_c;
   logic [WIDTH-3:0][PW-1:0]    w_cy;
   logic [PW-1:0]               w_sum;
   logic                        w_fin_valid;

   logic [PW-1:0]               p_d;
   logic [PW-1:0]               p_q;
   logic                        valid_d;
   logic                        valid_q;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_row
      for (genvar gj = 0; gj < WIDTH; gj++) begin : g_bit
         if ((gi == WIDTH-1) != (gj == WIDTH-1)) begin : g_inv
            assign w_pp[gi][gj] = ~(X[gj] & Y[gi]);
         end else begin : g_pos
            assign w_pp[gi][gj] = X[gj] & Y[gi];
         end
      end
      // Row 0 only occupies bits [WIDTH-1:0], so the constants ride in its free upper bits.
      if (gi == 0) begin : g_corr
         assign w_row[gi] = PW'(w_pp[gi]) | C_CORR;
      end else begin : g_shift
         assign w_row[gi] = PW'(w_pp[gi]) << gi;
      end
   end

   assign w_acc_s[0] = w_row[0];
   assign w_acc_c[0] = w_row[1];

   for (genvar gk = 0; gk < WIDTH-2; gk++) begin : g_csa
      bw_csa_row #(.N(PW)) u_csa (
         .a_i     (w_acc_s[gk]),
         .b_i     (w_acc_c[gk]),
         .c_i     (w_row[gk+2]),
         .sum_o   (w_acc_s[gk+1]),
         .carry_o (w_cy[gk])
      );
      assign w_acc_c[gk+1] = w_cy[gk] << 1;
   end

`ifdef BW_MUL_PIPE_EN
   logic [PW-1:0] s_q;
   logic [PW-1:0] c_q;
   logic          v1_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q  <= '0;
         c_q  <= '0;
         v1_q <= 1'b0;
      end else begin
         v1_q <= in_valid;
         if (in_valid) begin
            s_q <= w_acc_s[WIDTH-2];
            c_q <= w_acc_c[WIDTH-2];
         end
      end
   end

   assign w_sum       = s_q + c_q;
   assign w_fin_valid = v1_q;
`else
   assign w_sum       = w_acc_s[WIDTH-2] + w_acc_c[WIDTH-2];
   assign w_fin_valid = in_valid;
`endif

   assign valid_d = w_fin_valid;
   assign p_d     = w_fin_valid ? w_sum : p_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q     <= '0;
         valid_q <= 1'b0;
      end else begin
         p_q     <= p_d;
         valid_q <= valid_d;
      end
   end

   assign P         = p_q;
   assign out_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_baugh_wooley_mul16.sv
// +----------------------------------------------------------------------+
// | tb_baugh_wooley_mul16                                                |
// | Directed + random checks against an arithmetic delay-line model.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_baugh_wooley_mul16;
   import bw_mul_pkg::*;

   localparam int W = BW_DEF_WIDTH;
`ifdef BW_MUL_PIPE_EN
   localparam int L = 2;
`else
   localparam int L = 1;
`endif

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic [W-1:0]    x_in;
   logic [W-1:0]    y_in;
   logic            out_valid;
   logic [2*W-1:0]  p_out;

   int n_asserts = 0;
   int n_fail    = 0;

   typedef struct packed {
      logic           v;
      logic [2*W-1:0] p;
   } ent_t;

   ent_t           pend[$];
   logic           exp_v;
   logic [2*W-1:0] exp_p;

   baugh_wooley_mul16 #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .X         (x_in),
      .Y         (y_in),
      .out_valid (out_valid),
      .P         (p_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] expv);
      n_asserts++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      pend.delete();
      exp_v = 1'b0;
      exp_p = '0;
   endtask

   // Inputs seen at an edge surface L edges later; P keeps the last valid product.
   task automatic model_edge(input logic v, input logic [W-1:0] x, input logic [W-1:0] y);
      ent_t e;
      logic signed [2*W-1:0] prod;
      prod = $signed(x) * $signed(y);
      pend.push_back('{v: v, p: prod});
      if (pend.size() >= L) begin
         e = pend.pop_front();
         exp_v = e.v;
         if (e.v) exp_p = e.p;
      end
   endtask

   // Called just after a falling edge; returns just after the next falling edge.
   task automatic step(input string tag, input logic rst, input logic v,
                       input logic [W-1:0] x, input logic [W-1:0] y);
      rst_n    = rst;
      in_valid = v;
      x_in     = x;
      y_in     = y;
      @(posedge clk);
      if (!rst) model_reset();
      else      model_edge(v, x, y);
      @(negedge clk);
      chk({tag, ".valid"}, {{(2*W-1){1'b0}}, out_valid}, {{(2*W-1){1'b0}}, exp_v});
      chk({tag, ".P"}, p_out, exp_p);
   endtask

   task automatic corner(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [2*W-1:0] want);
      step(tag, 1'b1, 1'b1, x, y);
      repeat (L) step(tag, 1'b1, 1'b0, '0, '0);
      chk({tag, ".const"}, p_out, want);
   endtask

   initial begin
      int xs [6];
      int xn [3];
      xs = '{2, 12, 22, 32, 42, 52};
      xn = '{-48, -148, -248};

      rst_n    = 1'b0;
      in_valid = 1'b1;
      x_in     = 16'd5;
      y_in     = 16'd7;
      model_reset();
      #1;
      chk("reset0.valid", {{(2*W-1){1'b0}}, out_valid}, '0);
      chk("reset0.P", p_out, '0);
      @(negedge clk);
      repeat (3) step("reset", 1'b0, 1'b1, 16'd5, 16'd7);

      foreach (xs[i]) step("pos_sweep", 1'b1, 1'b1, W'(xs[i]), 16'd2);
      repeat (L) step("pos_tail", 1'b1, 1'b0, '0, '0);
      chk("pos_last", p_out, 32'd104);

      foreach (xn[i]) step("neg_sweep", 1'b1, 1'b1, W'(xn[i]), 16'd2);
      repeat (L) step("neg_tail", 1'b1, 1'b0, '0, '0);
      chk("neg_last", p_out, 32'hFFFFFE10);

      corner("c_minmin", 16'h8000, 16'h8000, 32'h40000000);
      corner("c_minmax", 16'h8000, 16'h7FFF, 32'hC0008000);
      corner("c_maxmax", 16'h7FFF, 16'h7FFF, 32'h3FFF0001);
      corner("c_m1m1",   16'hFFFF, 16'hFFFF, 32'h00000001);
      corner("c_zero",   16'h0000, 16'hFFFF, 32'h00000000);

      for (int i = 0; i < 10; i++)
         step("gaps", 1'b1, (i % 2) == 0, W'(i * 1000 - 3000), W'(-i - 7));
      repeat (L) step("gaps_tail", 1'b1, 1'b0, '0, '0);

      step("mid_a", 1'b1, 1'b1, 16'd1234, 16'd4321);
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("mid_rst.valid", {{(2*W-1){1'b0}}, out_valid}, '0);
      chk("mid_rst.P", p_out, '0);
      @(negedge clk);
      step("mid_hold", 1'b0, 1'b0, '0, '0);
      step("mid_b", 1'b1, 1'b1, 16'hFFF0, 16'd3);
      repeat (L + 2) step("mid_tail", 1'b1, 1'b0, '0, '0);
      chk("mid_b_const", p_out, 32'hFFFFFFD0);

      for (int i = 0; i < 10000; i++)
         step("random", 1'b1, $urandom_range(0, 9) != 0, W'($urandom), W'($urandom));
      repeat (L) step("random_tail", 1'b1, 1'b0, '0, '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
